moore_seq_detector_1011: RTL and testbench
==========================================

Name: moore_seq_detector_1011

Overview:
Moore-type serial pattern detector that watches a 1-bit input stream and asserts its output for one state-cycle after the pattern 1-0-1-1 completes. Overlapping occurrences are detected. Sits on any serial bit stream sampled by the system clock. Also provides current-state and saturating detection-count outputs for debug and status.

Parameters:
CNT_W, 8, width of the saturating detection counter detect_count.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
sequence_in  input  1  serial data bit, sampled on every rising clock edge
detector_out  output  1  high while FSM is in state S1011 (pattern just completed)
state_out  output  3  current FSM state encoding (debug)
detect_count  output  CNT_W  number of pattern detections since reset, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Single clock domain; all registers update on rising edge of clock only; no asynchronous paths.
- reset=1 at a rising edge: state<=S0, detect_count<=0. reset takes priority over sequence_in.
- State encoding, registered, 3 bits: S0=0 (idle), S1=1 (seen "1"), S10=2 (seen "10"), S101=3 (seen "101"), S1011=4 (seen "1011"). Codes 5-7 are illegal and go to S0 on the next edge.
- Transitions, input 0 / input 1:
  - S0: 0->S0, 1->S1
  - S1: 0->S10, 1->S1
  - S10: 0->S0, 1->S101
  - S101: 0->S10, 1->S1011
  - S1011: 0->S10, 1->S1 (overlap: trailing "1" is reused as a new leading "1")
- detector_out = (state==S1011). It is a pure decode of the state register with no dependence on the current sequence_in (Moore).
- Latency: detector_out rises in the clock cycle after the edge that samples the 4th pattern bit. It stays high for exactly one cycle, because S1011 always exits on the next edge.
- Back-to-back detections (e.g. 1011011) give pulses separated by at least two low cycles; detector_out can never be high for two consecutive cycles.
- detect_count increments by 1 on each edge that enters S1011. It holds at 2^CNT_W-1 (no wrap).
- state_out = state register value.
- Reset outputs: detector_out=0, state_out=0, detect_count=0.
- Reset asserted mid-pattern (e.g. in S101): pattern progress is discarded and the next edge gives S0. Reset asserted while in S1011: detector_out drops to 0 after that edge.
- sequence_in X/Z is not supported; the bench drives only 0/1.

Test Plan:
- Reset: reset=1 for one edge with sequence_in=0 -> detector_out=0, state_out=0, detect_count=0.
- Basic detect: after reset, drive 1,0,1,1,0,0 on successive edges -> state_out 1,2,3,4,2,0. detector_out=1 only in the cycle after the 4th edge, otherwise 0. detect_count becomes 1.
- Overlap: drive 1,0,1,1,0,1,1 -> two single-cycle detector_out pulses, after the 4th and 7th edges. detect_count=2.
- Near-misses: drive 1,0,0,1,1,1,0,1,0 -> detector_out stays 0 throughout. States pass through S10 then S0 on the "00", and S1 is held on repeated 1s.
- Reset mid-pattern: drive 1,0,1, then reset=1 with sequence_in=1 for one edge, then 1 -> no pulse, state_out=1 after the final edge.
- Saturation: with CNT_W=2, drive "1011" repeatedly 5 times -> detect_count stops at 3. detector_out still pulses on every detection.

Source files
------------

// File: rtl/moore_seq_detector_1011.sv
// moore_seq_detector_1011: Moore FSM flagging serial pattern 1011 (overlapping),
// with a debug state output and a saturating detection counter.
module moore_seq_detector_1011 #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sequence_in,
    output logic             detector_out,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] detect_count
);
    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = sequence_in ? S1    : S0;
            S1:      state_d = sequence_in ? S1    : S10;
            S10:     state_d = sequence_in ? S101  : S0;
            S101:    state_d = sequence_in ? S1011 : S10;
            S1011:   state_d = sequence_in ? S1    : S10;
            default: state_d = S0;
        endcase
        // S1011 is only reachable from S101, so this counts entries, not dwell cycles
        count_d = (state_d == S1011 && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    end
    always_comb begin
        detector_out = (state_q == S1011);
        state_out    = state_q;
        detect_count = count_q;
    end
endmodule

// File: tb/tb_moore_seq_detector_1011.sv
// tb_moore_seq_detector_1011: directed plus random stream checked against a
// pattern-matching model; a second instance with CNT_W=2 checks saturation.
module tb_moore_seq_detector_1011;
    logic       clock;
    logic       reset;
    logic       sequence_in;
    logic       det, det_s;
    logic [2:0] st, st_s;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
    int         checks = 0;
    int         passes = 0;
    bit         hist[$];
    int         m_cnt, m_cnt_s;
    bit         prev_det;
    bit         pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    moore_seq_detector_1011 dut (
        .clock(clock), .reset(reset), .sequence_in(sequence_in),
        .detector_out(det), .state_out(st), .detect_count(cnt)
    );
    moore_seq_detector_1011 #(.CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .sequence_in(sequence_in),
        .detector_out(det_s), .state_out(st_s), .detect_count(cnt_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Progress = longest suffix of the bits seen since reset that is a prefix of 1011.
    function automatic int match_len();
        for (int k = 4; k >= 1; k--) begin
            if (hist.size() >= k) begin
                bit ok = 1'b1;
                for (int i = 0; i < k; i++)
                    if (hist[hist.size() - k + i] != pat[i]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input bit b, input bit r);
        int e;
        sequence_in = b;
        reset       = r;
        @(posedge clock);
        if (r) begin
            hist.delete();
            m_cnt   = 0;
            m_cnt_s = 0;
        end else begin
            hist.push_back(b);
            if (hist.size() > 4) void'(hist.pop_front());
            if (match_len() == 4) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
        end
        @(negedge clock);
        e = match_len();
        check("state", int'(st), e);
        check("detect", int'(det), int'(e == 4));
        check("count", int'(cnt), m_cnt);
        check("state_w2", int'(st_s), e);
        check("detect_w2", int'(det_s), int'(e == 4));
        check("count_w2", int'(cnt_s), m_cnt_s);
        check("no_double_pulse", int'(prev_det & det), 0);
        prev_det = det;
    endtask

    task automatic drive(input string bits);
        for (int i = 0; i < bits.len(); i++) step(bits[i] == "1", 1'b0);
    endtask

    initial begin
        sequence_in = 1'b0;
        reset       = 1'b1;
        prev_det    = 1'b0;
        step(1'b0, 1'b1);
        check("reset_state", int'(st), 0);
        check("reset_count", int'(cnt), 0);
        drive("101100");
        check("basic_count", int'(cnt), 1);
        step(1'b0, 1'b1);
        drive("1011011");
        check("overlap_count", int'(cnt), 2);
        step(1'b0, 1'b1);
        drive("100111010");
        check("nearmiss_count", int'(cnt), 0);
        step(1'b0, 1'b1);
        drive("101");
        step(1'b1, 1'b1);
        check("midreset_state", int'(st), 0);
        drive("1");
        check("midreset_final", int'(st), 1);
        step(1'b0, 1'b1);
        drive("10111011101110111011");
        check("sat_count_w2", int'(cnt_s), 3);
        check("sat_count_w8", int'(cnt), 5);
        drive("1101100");
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 60), $urandom_range(0, 49) == 0);
        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 99) < 70), 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
